// File: rtl/seq_alu_if.sv
// seq_alu_if: operation request/result handshake between decode and seq_alu.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready for requests, out_valid/out_ready for results.
interface seq_alu_if #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] rn;
    logic [WIDTH-1:0] rm;
    logic [IMM_W-1:0] imm;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rd;
    logic             z;
    logic             n;
    logic             v;
    logic             c;
    logic             err;

    modport master (
        output in_valid, op, rn, rm, imm, out_ready,
        input  in_ready, out_valid, rd, z, n, v, c, err
    );

    modport slave (
        input  in_valid, op, rn, rm, imm, out_ready,
        output in_ready, out_valid, rd, z, n, v, c, err
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with one-bit-per-cycle shifts; SEQ_ALU_MUL_EN adds an iterative multiply.
// Latency: 1 cycle for single-cycle ops, k cycles for shift by k>0, WIDTH cycles for MUL.
// Backpressure: result held in DONE until out_ready; in_ready low while iterating.
module seq_alu #(
    parameter int WIDTH   = 16,
    parameter int IMM_W   = 9,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_PASS = 4'd4;
    localparam logic [3:0] OP_ZEXT = 4'd5;
    localparam logic [3:0] OP_SEXT = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_ASR  = 4'd9;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd10;
`endif
    localparam int MSB = WIDTH - 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_rd;
    logic               r_z, r_n, r_v, r_c, r_err, r_out_valid;
    logic [3:0]         r_op;
    logic [SHAMT_W-1:0] r_cnt;
`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0]   r_mhi;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   w_mhi_src;
    logic [WIDTH-1:0]   w_mcand_src;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH-1:0]   w_mhi_next;
`endif

    logic               w_in_ready;
    logic               w_accept;
    logic               w_iter;
    logic [SHAMT_W-1:0] w_k;
    logic [SHAMT_W-1:0] w_cnt_init;
    logic [3:0]         w_sop;
    logic [WIDTH-1:0]   w_src;
    logic [WIDTH-1:0]   w_step;
    logic               w_step_bit;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_res_v, w_res_c, w_res_err;

    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_k        = bus.rm[SHAMT_W-1:0];

    always_comb begin
        w_iter     = 1'b0;
        w_cnt_init = w_k - 1'b1;
        if ((bus.op == OP_SHL) || (bus.op == OP_SHR) || (bus.op == OP_ASR))
            w_iter = (w_k != '0);
`ifdef SEQ_ALU_MUL_EN
        if (bus.op == OP_MUL) begin
            w_iter     = 1'b1;
            w_cnt_init = SHAMT_W'(WIDTH - 1);
        end
`endif
    end

    // One iteration step; the accept cycle performs the first step so the
    // result lands after exactly k (or WIDTH) clock edges.
    always_comb begin
        w_sop      = w_accept ? bus.op : r_op;
        w_src      = w_accept ? bus.rn : r_rd;
        w_step     = w_src;
        w_step_bit = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        if (w_accept && (bus.op == OP_MUL))
            w_src = bus.rm;
        w_mhi_src   = w_accept ? '0 : r_mhi;
        w_mcand_src = w_accept ? bus.rn : r_mcand;
        w_msum      = {1'b0, w_mhi_src} + (w_src[0] ? {1'b0, w_mcand_src} : '0);
        w_mhi_next  = w_msum[WIDTH:1];
`endif
        case (w_sop)
            OP_SHL: begin
                w_step_bit = w_src[MSB];
                w_step     = {w_src[MSB-1:0], 1'b0};
            end
            OP_SHR: begin
                w_step_bit = w_src[0];
                w_step     = {1'b0, w_src[MSB:1]};
            end
            OP_ASR: begin
                w_step_bit = w_src[0];
                w_step     = {w_src[MSB], w_src[MSB:1]};
            end
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: begin
                w_step     = {w_msum[0], w_src[MSB:1]};
                w_step_bit = |w_mhi_next;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_sum     = '0;
        w_res     = '0;
        w_res_v   = 1'b0;
        w_res_c   = 1'b0;
        w_res_err = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_sum   = {1'b0, bus.rn} + {1'b0, bus.rm};
                w_res   = w_sum[MSB:0];
                w_res_c = w_sum[WIDTH];
                w_res_v = (bus.rn[MSB] == bus.rm[MSB]) && (w_res[MSB] != bus.rn[MSB]);
            end
            OP_SUB: begin
                w_sum   = {1'b0, bus.rn} + {1'b0, ~bus.rm} + (WIDTH+1)'(1);
                w_res   = w_sum[MSB:0];
                w_res_c = w_sum[WIDTH];
                w_res_v = (bus.rn[MSB] != bus.rm[MSB]) && (w_res[MSB] != bus.rn[MSB]);
            end
            OP_AND:  w_res = bus.rn & bus.rm;
            OP_OR:   w_res = bus.rn | bus.rm;
            OP_PASS: w_res = bus.rn;
            OP_ZEXT: w_res = {{(WIDTH-IMM_W){1'b0}}, bus.imm};
            OP_SEXT: w_res = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
            OP_SHL, OP_SHR, OP_ASR: w_res = bus.rn;
`ifdef SEQ_ALU_MUL_EN
            OP_MUL:  w_res = '0;
`endif
            default: w_res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd        <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
            r_c         <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_op        <= '0;
            r_cnt       <= '0;
`ifdef SEQ_ALU_MUL_EN
            r_mhi       <= '0;
            r_mcand     <= '0;
`endif
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_rd  <= w_step;
                    r_c   <= w_step_bit;
                    r_cnt <= r_cnt - 1'b1;
`ifdef SEQ_ALU_MUL_EN
                    r_mhi <= w_mhi_next;
`endif
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_z         <= (w_step == '0);
                        r_n         <= w_step[MSB];
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_op  <= bus.op;
                        r_err <= w_res_err;
                        r_v   <= 1'b0;
                        if (w_iter) begin
                            r_rd  <= w_step;
                            r_c   <= w_step_bit;
                            r_cnt <= w_cnt_init;
`ifdef SEQ_ALU_MUL_EN
                            r_mhi   <= w_mhi_next;
                            r_mcand <= bus.rn;
`endif
                            if (w_cnt_init == '0) begin
                                r_state     <= S_DONE;
                                r_out_valid <= 1'b1;
                                r_z         <= (w_step == '0);
                                r_n         <= w_step[MSB];
                            end else begin
                                r_state     <= S_SHIFT;
                                r_out_valid <= 1'b0;
                            end
                        end else begin
                            r_rd        <= w_res;
                            r_z         <= (w_res == '0);
                            r_n         <= w_res[MSB];
                            r_v         <= w_res_v;
                            r_c         <= w_res_c;
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end else if ((r_state == S_DONE) && bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.rd        = r_rd;
    assign bus.z         = r_z;
    assign bus.n         = r_n;
    assign bus.v         = r_v;
    assign bus.c         = r_c;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;
    localparam int W  = 16;
    localparam int IW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    seq_alu_if #(.WIDTH(W), .IMM_W(IW)) bus ();
    seq_alu #(.WIDTH(W), .IMM_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Expected result packed as {rd, z, n, v, c, err}, plus latency in clock edges.
    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic [8:0] im, output logic [20:0] exp_v, output int lat);
        logic [15:0] r;
        logic        v, c, e;
        logic [31:0] t;
        int          k, s, si;
        r = '0; v = 0; c = 0; e = 0; lat = 1;
        k = int'(b[3:0]);
        case (op)
            4'd0: begin
                t = 32'(a) + 32'(b); r = t[15:0]; c = t[16];
                s = int'($signed(a)) + int'($signed(b)); v = (s > 32767) || (s < -32768);
            end
            4'd1: begin
                r = a - b; c = (a >= b);
                s = int'($signed(a)) - int'($signed(b)); v = (s > 32767) || (s < -32768);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a;
            4'd5: r = 16'(im);
            4'd6: begin si = int'(im); if (im[8]) si = si - 512; r = si[15:0]; end
            4'd7: begin
                r = a << k;
                if (k != 0) begin t = 32'(a) << k; c = t[16]; lat = k; end
            end
            4'd8: begin r = a >> k; if (k != 0) begin c = a[k-1]; lat = k; end end
            4'd9: begin r = $signed(a) >>> k; if (k != 0) begin c = a[k-1]; lat = k; end end
`ifdef SEQ_ALU_MUL_EN
            4'd10: begin t = 32'(a) * 32'(b); r = t[15:0]; c = (t[31:16] != 0); lat = 16; end
`endif
            default: e = 1;
        endcase
        exp_v = {r, (r == 16'd0), r[15], v, c, e};
    endfunction

    // Drives one request with out_ready high and returns what came back; no checking here.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [8:0] im, output logic [20:0] obs, output int lat);
        int guard = 0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.op = op; bus.rn = a; bus.rm = b; bus.imm = im;
        #1;
        while (!bus.in_ready && guard < 100) begin @(negedge clk); #1; guard++; end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom); bus.rn = 16'($urandom); bus.rm = 16'($urandom); bus.imm = 9'($urandom);
        lat = 1;
        #1;
        while (!bus.out_valid && lat < 200) begin @(negedge clk); #1; lat++; end
        obs = {bus.rd, bus.z, bus.n, bus.v, bus.c, bus.err};
    endtask

    task automatic test_reset();
        logic [20:0] obs;
        int          stale;
        obs = {bus.rd, bus.z, bus.n, bus.v, bus.c, bus.err};
        total++; if (obs !== 21'd0) begin bad++; $display("FAIL reset_regs: observed %h expected 0", obs); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_ovld: observed %b expected 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_irdy: observed %b expected 1", bus.in_ready); end
        // Interrupt a SHL by 5 after two shift cycles.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 4'd7; bus.rn = 16'h1357; bus.rm = 16'd5;
        @(posedge clk);
        @(negedge clk); bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.rd !== 16'd0) begin
            bad++; $display("FAIL midreset: observed ovld=%b rd=%h expected ovld=0 rd=0000", bus.out_valid, bus.rd);
        end
        @(negedge clk); rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midreset_irdy: observed %b expected 1", bus.in_ready); end
        stale = 0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); if (bus.out_valid) stale++; end
        total++; if (stale != 0) begin bad++; $display("FAIL stale_result: observed %0d valid cycles expected 0", stale); end
    endtask

    task automatic test_directed();
        logic [3:0]  ops [11] = '{4'd0, 4'd1, 4'd6, 4'd5, 4'd1, 4'd9, 4'd8, 4'd7, 4'd12, 4'd0, 4'd10};
        logic [15:0] as  [11] = '{16'h7FFF, 16'h0003, 16'h0, 16'h0, 16'h0005, 16'h8001, 16'h0001,
                                  16'h1234, 16'hAAAA, 16'h0001, 16'h0100};
        logic [15:0] bs  [11] = '{16'h0001, 16'h0005, 16'h0, 16'h0, 16'h0005, 16'h0003, 16'h0001,
                                  16'h0000, 16'h5555, 16'h0001, 16'h0100};
        logic [8:0]  ims [11] = '{9'h0, 9'h0, 9'h100, 9'h100, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
        logic [20:0] obs, exp_v;
        int          lat, exp_lat;
        for (int i = 0; i < 11; i++) begin
            model(ops[i], as[i], bs[i], ims[i], exp_v, exp_lat);
            issue(ops[i], as[i], bs[i], ims[i], obs, lat);
            total++; if (obs !== exp_v) begin
                bad++; $display("FAIL dir%0d_op%0d: observed %h expected %h", i, ops[i], obs, exp_v);
            end
            total++; if (lat != exp_lat) begin
                bad++; $display("FAIL dir%0d_lat: observed %0d expected %0d", i, lat, exp_lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [20:0] obs, exp_v, exp_or;
        int          lat;
        model(4'd0, 16'h1234, 16'h4321, 9'h0, exp_v, lat);
        model(4'd3, 16'h00F0, 16'h0F00, 9'h0, exp_or, lat);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.op = 4'd0; bus.rn = 16'h1234; bus.rm = 16'h4321;
        @(posedge clk);
        @(negedge clk); bus.in_valid = 1'b0; bus.rn = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            obs = {bus.rd, bus.z, bus.n, bus.v, bus.c, bus.err};
            total++; if (obs !== exp_v || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL hold%0d: observed %h ovld=%b irdy=%b expected %h ovld=1 irdy=0",
                                i, obs, bus.out_valid, bus.in_ready, exp_v);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b1; bus.op = 4'd3; bus.rn = 16'h00F0; bus.rm = 16'h0F00; bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_irdy: observed %b expected 1", bus.in_ready); end
        @(posedge clk);
        @(negedge clk); bus.in_valid = 1'b0;
        #1;
        obs = {bus.rd, bus.z, bus.n, bus.v, bus.c, bus.err};
        total++; if (bus.out_valid !== 1'b1 || obs !== exp_or) begin
            bad++; $display("FAIL b2b_result: observed ovld=%b %h expected ovld=1 %h", bus.out_valid, obs, exp_or);
        end
        @(posedge clk);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [15:0] a, b;
        logic [8:0]  im;
        logic [20:0] obs, exp_v;
        int          lat, exp_lat;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15)); a = 16'($urandom); b = 16'($urandom); im = 9'($urandom);
            model(op, a, b, im, exp_v, exp_lat);
            issue(op, a, b, im, obs, lat);
            total++; if (obs !== exp_v) begin
                bad++; $display("FAIL rand%0d_op%0d: observed %h expected %h (a=%h b=%h imm=%h)", i, op, obs, exp_v, a, b, im);
            end
            total++; if (lat != exp_lat) begin
                bad++; $display("FAIL rand%0d_lat: observed %0d expected %0d", i, lat, exp_lat);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.op = '0; bus.rn = '0; bus.rm = '0; bus.imm = '0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
